// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out converter. A WIDTH-bit word is accepted on a
// valid/ready handshake and sent one bit per clock on data_out. frame_valid
// marks the bits of a frame, and last_bit marks the final bit of the word.
// A new word can be accepted while the final bit of the current word is on the
// line, so a continuously offered stream is sent with no gap cycles.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous active-low reset
//   load_valid   a parallel word is offered this cycle
//   load_data    the parallel word to serialize
//   load_ready   block accepts load_data this cycle (combinational)
//   data_out     serial bit stream (registered)
//   frame_valid  data_out carries a frame bit (registered)
//   last_bit     data_out carries the final bit of the word (registered)
//   busy         high while a word is being shifted out
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             data_out,
  output logic             frame_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Machine state
  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  // Bits of the current word that have not yet reached data_out. The bit
  // placed on data_out is consumed at the same time, so the head of this
  // register is always the bit to send on the next edge.
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  // Index (in transmission order) of the bit currently on data_out
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  logic             data_out_reg;
  logic             data_out_next;
  logic             frame_valid_reg;
  logic             frame_valid_next;
  logic             last_bit_reg;
  logic             last_bit_next;

  logic             transfer;

  // Bit-order dependent views of the incoming word and of the shift register
  logic             load_head;   // first bit of the incoming word
  logic [WIDTH-1:0] load_rest;   // remaining bits, head-aligned
  logic             shift_head;  // next bit to send from the shift register
  logic [WIDTH-1:0] shift_rest;  // shift register after removing shift_head

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign load_head  = load_data[WIDTH-1];
      assign load_rest  = {load_data[WIDTH-2:0], 1'b0};
      assign shift_head = shift_reg[WIDTH-1];
      assign shift_rest = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign load_head  = load_data[0];
      assign load_rest  = {1'b0, load_data[WIDTH-1:1]};
      assign shift_head = shift_reg[0];
      assign shift_rest = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // Ready while idle, or while the final bit of the current word is on the
  // line so the next word follows with no idle cycle.
  assign load_ready = (state_reg == ST_IDLE) || last_bit_reg;
  assign transfer   = load_valid && load_ready;
  assign cnt_inc    = cnt_reg + CNT_ONE;

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    cnt_next         = cnt_reg;
    data_out_next    = data_out_reg;
    frame_valid_next = frame_valid_reg;
    last_bit_next    = last_bit_reg;

    if (transfer) begin
      // New word: its first bit goes straight to the output register so it
      // appears in the cycle right after the handshake edge.
      state_next       = ST_SHIFT;
      shift_next       = load_rest;
      cnt_next         = '0;
      data_out_next    = load_head;
      frame_valid_next = 1'b1;
      last_bit_next    = 1'b0;  // WIDTH >= 2, so bit 0 is never the last
    end else if (state_reg == ST_SHIFT) begin
      if (last_bit_reg) begin
        // Word finished and nothing offered: return to a quiet line
        state_next       = ST_IDLE;
        shift_next       = '0;
        cnt_next         = '0;
        data_out_next    = 1'b0;
        frame_valid_next = 1'b0;
        last_bit_next    = 1'b0;
      end else begin
        shift_next       = shift_rest;
        cnt_next         = cnt_inc;
        data_out_next    = shift_head;
        frame_valid_next = 1'b1;
        last_bit_next    = (cnt_inc == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      shift_reg       <= '0;
      cnt_reg         <= '0;
      data_out_reg    <= 1'b0;
      frame_valid_reg <= 1'b0;
      last_bit_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      cnt_reg         <= cnt_next;
      data_out_reg    <= data_out_next;
      frame_valid_reg <= frame_valid_next;
      last_bit_reg    <= last_bit_next;
    end
  end

  assign data_out    = data_out_reg;
  assign frame_valid = frame_valid_reg;
  assign last_bit    = last_bit_reg;
  assign busy        = (state_reg == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives an MSB-first and an LSB-first 8-bit serializer from the same stimulus.
// The reference keeps, for each instance, a queue of the bits still to appear
// on data_out (front = bit currently shown). Receiver registers fed from
// data_out rebuild each word for the loopback comparison.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;

  logic dm_load_ready, dm_data_out, dm_frame_valid, dm_last_bit, dm_busy;
  logic dl_load_ready, dl_data_out, dl_frame_valid, dl_last_bit, dl_busy;

  int vectors = 0;
  int miscompares = 0;
  int loop_words = 0;

  bit         qm[$];     // MSB-first bits still to be shown
  bit         ql[$];     // LSB-first bits still to be shown
  logic [7:0] words[$];  // word currently in flight
  logic [7:0] sr_m = 8'h00;
  logic [7:0] sr_l = 8'h00;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(dm_load_ready), .data_out(dm_data_out),
    .frame_valid(dm_frame_valid), .last_bit(dm_last_bit), .busy(dm_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(dl_load_ready), .data_out(dl_data_out),
    .frame_valid(dl_frame_valid), .last_bit(dl_last_bit), .busy(dl_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic fv, lb, dm, dl, rdy;
    fv  = (qm.size() != 0);
    lb  = (qm.size() == 1);
    rdy = (qm.size() <= 1);
    dm  = fv ? qm[0] : 1'b0;
    dl  = fv ? ql[0] : 1'b0;
    chk("msb_data_out",    dm_data_out,    dm);
    chk("msb_frame_valid", dm_frame_valid, fv);
    chk("msb_last_bit",    dm_last_bit,    lb);
    chk("msb_busy",        dm_busy,        fv);
    chk("msb_load_ready",  dm_load_ready,  rdy);
    chk("lsb_data_out",    dl_data_out,    dl);
    chk("lsb_frame_valid", dl_frame_valid, fv);
    chk("lsb_last_bit",    dl_last_bit,    lb);
    chk("lsb_busy",        dl_busy,        fv);
    chk("lsb_load_ready",  dl_load_ready,  rdy);
  endtask

  // One clock: called at a falling edge, drives inputs, advances the
  // reference across the rising edge, compares at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d);
    bit xfer;
    load_valid = v;
    load_data  = d;
    sr_m = {sr_m[6:0], dm_data_out};
    sr_l = {dl_data_out, sr_l[7:1]};
    if (reset && qm.size() == 1 && words.size() != 0) begin
      chk("loop_msb_word", sr_m, words[0]);
      chk("loop_lsb_word", sr_l, words[0]);
      void'(words.pop_front());
      loop_words++;
    end
    xfer = v && reset && (qm.size() <= 1);
    @(posedge clk);
    if (!reset) begin
      qm.delete(); ql.delete(); words.delete();
    end else begin
      if (qm.size() != 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (xfer) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back(d[7-i]);
          ql.push_back(d[i]);
        end
        words.push_back(d);
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic assert_reset();
    reset = 1'b0;
    #1;
    qm.delete(); ql.delete(); words.delete();
    chk("rst_async_data_out",    dm_data_out,    1'b0);
    chk("rst_async_frame_valid", dm_frame_valid, 1'b0);
    chk("rst_async_busy",        dm_busy,        1'b0);
    chk("rst_async_last_bit",    dl_last_bit,    1'b0);
    compare_all();
  endtask

  initial begin
    logic [7:0]  bm, bl, lb, sq;
    logic [15:0] b16, r16;
    int          fvc;
    logic        v;

    // Power-up reset
    #2 reset = 1'b0;
    #1;
    chk("por_data_out",    dm_data_out,    1'b0);
    chk("por_frame_valid", dm_frame_valid, 1'b0);
    chk("por_busy",        dl_busy,        1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("por_load_ready", dm_load_ready, 1'b1);
    compare_all();

    // 8'hA5 on both bit orders
    step(1'b1, 8'hA5);
    bm = '0; bl = '0; lb = '0; fvc = 0;
    for (int i = 0; i < 8; i++) begin
      bm    = {bm[6:0], dm_data_out};
      bl[i] = dl_data_out;
      lb    = {lb[6:0], dm_last_bit};
      if (dm_frame_valid) fvc++;
      step(1'b0, 8'h00);
    end
    chk("a5_msb_bits",     bm,  8'hA5);
    chk("a5_lsb_bits",     bl,  8'hA5);
    chk("a5_last_pos",     lb,  8'h01);
    chk("a5_frame_cycles", fvc, 8);
    chk("a5_idle_after",   dm_frame_valid | dm_busy, 1'b0);

    // 8'h01: LSB-first sends 1 then seven 0s
    step(1'b1, 8'h01);
    bm = '0; sq = '0;
    for (int i = 0; i < 8; i++) begin
      sq = {sq[6:0], dl_data_out};
      bm = {bm[6:0], dm_data_out};
      step(1'b0, 8'h00);
    end
    chk("w01_lsb_seq", sq, 8'h80);
    chk("w01_msb_seq", bm, 8'h01);

    // F0 then 0F with load_valid held high
    step(1'b1, 8'hF0);
    b16 = '0; r16 = '0; fvc = 0;
    for (int k = 0; k < 16; k++) begin
      b16 = {b16[14:0], dm_data_out};
      r16 = {r16[14:0], dm_load_ready};
      if (dm_frame_valid) fvc++;
      step((k < 15) ? 1'b1 : 1'b0, 8'h0F);
    end
    chk("stream_bits",   b16, 16'hF00F);
    chk("stream_ready",  r16, 16'h0101);
    chk("stream_frames", fvc, 16);

    // Abort 8'hFF mid-word, then a clean 8'h81
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    assert_reset();
    step(1'b1, 8'h55);
    step(1'b1, 8'hAA);
    chk("rst_no_capture", dm_frame_valid | dl_frame_valid, 1'b0);
    reset = 1'b1;
    step(1'b1, 8'h81);
    bm = '0;
    for (int i = 0; i < 8; i++) begin
      bm = {bm[6:0], dm_data_out};
      step(1'b0, 8'h00);
    end
    chk("post_rst_81", bm, 8'h81);

    // 200 back-to-back random words, load_data changing every cycle
    for (int n = 0; n < 1608; n++) step(1'b1, 8'($urandom()));
    chk("loop_words_min", (loop_words >= 200) ? 1 : 0, 1);

    // Random gaps and occasional mid-word resets
    for (int n = 0; n < 800; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        assert_reset();
        step(v, 8'($urandom()));
        reset = 1'b1;
      end else begin
        step(v, 8'($urandom()));
      end
    end
    for (int n = 0; n < 10; n++) step(1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
